// File: rtl/univ_shift_reg_rst_if.sv
// Control, data and status bundle for the universal shift register.
// The master drives mode/data, the slave (the register itself) drives state.
interface univ_shift_reg_rst_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             clr;
    logic [1:0]       mode;
    logic             rotate;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] nQ;
    logic             sout_r;
    logic             sout_l;

    modport master (
        output en, clr, mode, rotate, sin_r, sin_l, D,
        input  Q, nQ, sout_r, sout_l
    );

    modport slave (
        input  en, clr, mode, rotate, sin_r, sin_l, D,
        output Q, nQ, sout_r, sout_l
    );
endinterface

// File: rtl/univ_shift_reg_rst.sv
// N-bit universal register: hold / shift right / shift left / parallel load,
// optional rotate, synchronous clear, clock enable and async active-low reset.
module univ_shift_reg_rst #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input logic                 clock,
    input logic                 reset,
    univ_shift_reg_rst_if.slave bus
);
    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] shr_s;
    logic [WIDTH-1:0] shl_s;
    logic             msb_in_s;
    logic             lsb_in_s;

    // Bits entering at each end: the wrapped-around bit when rotating, else serial inputs.
    always_comb begin
        if (bus.rotate) begin
            msb_in_s = q_r[0];
            lsb_in_s = q_r[WIDTH-1];
        end else begin
            msb_in_s = bus.sin_r;
            lsb_in_s = bus.sin_l;
        end
    end

    // A one-bit register has no neighbours, so it simply takes the entering bit.
    generate
        if (WIDTH == 1) begin : g_narrow
            assign shr_s = msb_in_s;
            assign shl_s = lsb_in_s;
        end else begin : g_wide
            assign shr_s = {msb_in_s, q_r[WIDTH-1:1]};
            assign shl_s = {q_r[WIDTH-2:0], lsb_in_s};
        end
    endgenerate

    // Next-state select: clear beats enable, enable gates the mode operation.
    always_comb begin
        next_s = q_r;
        if (bus.clr) begin
            next_s = {WIDTH{1'b0}};
        end else if (bus.en) begin
            case (bus.mode)
                MODE_HOLD: next_s = q_r;
                MODE_SHR:  next_s = shr_s;
                MODE_SHL:  next_s = shl_s;
                MODE_LOAD: next_s = bus.D;
                default:   next_s = q_r;
            endcase
        end else begin
            next_s = q_r;
        end
    end

    // State register; reset discards any in-flight shift immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_r <= RESET_VALUE;
        end else begin
            q_r <= next_s;
        end
    end

    // Derived outputs follow Q so the serial-out bit is visible before the edge that drops it.
    assign bus.Q      = q_r;
    assign bus.nQ     = ~q_r;
    assign bus.sout_r = q_r[0];
    assign bus.sout_l = q_r[WIDTH-1];
endmodule

// File: doc/univ_shift_reg_rst.md
Name: univ_shift_reg_rst

Overview:
- Parametrised N-bit universal register bank: a vector of posedge D flip-flops with per-cycle mode select.
- Modes: hold, shift right, shift left, parallel load, plus a rotate option, synchronous clear and clock enable.
- Successor to the single-bit reset flip-flop; base storage element for counters, serial links and datapath registers in the sequential-circuits library.
- Q and complement nQ are provided, as on the single-bit flip-flop.

Parameters:
- WIDTH, 8, number of bits stored; legal range 1..64.
- RESET_VALUE, 0, value loaded into Q on asynchronous reset; WIDTH bits wide.

Ports:
- clock  input  1  system clock; all state changes on the rising edge except reset.
- reset  input  1  asynchronous, active-low reset; 0 forces Q = RESET_VALUE immediately.
- en  input  1  clock enable; 0 holds state regardless of mode.
- clr  input  1  synchronous clear; 1 loads all-zeros on the next edge, even when en = 0.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- rotate  input  1  1 makes shifts wrap around internally; sin_r and sin_l are ignored.
- sin_r  input  1  serial input entering at MSB during shift right.
- sin_l  input  1  serial input entering at LSB during shift left.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  registered state.
- nQ  output  WIDTH  bitwise complement of Q, combinational from Q.
- sout_r  output  1  equals Q[0], the bit shifted out on shift right.
- sout_l  output  1  equals Q[WIDTH-1], the bit shifted out on shift left.

Behaviour:
- Reset (reset = 0, asynchronous, no clock needed): Q = RESET_VALUE, nQ = ~RESET_VALUE, sout_r = RESET_VALUE[0], sout_l = RESET_VALUE[WIDTH-1].
  - Reset held low: clock edges are ignored.
  - Reset deassertion: the first edge with reset = 1 acts normally.
- Priority at each rising edge with reset = 1: clr > en > mode.
  - clr = 1: Q <= 0, regardless of en, mode or rotate.
  - clr = 0, en = 0: Q unchanged.
  - clr = 0, en = 1: the mode operation applies.
- Mode operations:
  - mode 00: Q unchanged.
  - mode 01, rotate 0: Q <= {sin_r, Q[WIDTH-1:1]}.
  - mode 01, rotate 1: Q <= {Q[0], Q[WIDTH-1:1]}.
  - mode 10, rotate 0: Q <= {Q[WIDTH-2:0], sin_l}.
  - mode 10, rotate 1: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - mode 11: Q <= D; rotate is ignored.
- Latency: one clock from the sampled inputs to the new Q. nQ, sout_r and sout_l follow Q combinationally, with no additional register.
- WIDTH = 1:
  - shift right, rotate 0: Q <= sin_r.
  - shift left, rotate 0: Q <= sin_l.
  - rotate 1 in either direction: Q unchanged.
  - sout_r = sout_l = Q[0].
- Serial outputs present the pre-edge value. The bit shifted out is visible on sout_* before the edge that discards it.
- No X propagation from unused inputs: in modes 00 and 11, sin_r, sin_l and rotate must not affect Q.
- Reset asserted mid-operation, including during a shift sequence: state is discarded immediately and no partial shift is retained.
- Structure: storage is WIDTH instances of a reset-capable edge-triggered flip-flop cell, with the next-state mux per bit ahead of each cell. Behavioural always_ff is also acceptable if it is gate-equivalent.

Test Plan (WIDTH = 8, RESET_VALUE = 8'hA5 unless noted):
- Async reset: drive reset = 0 between clock edges -> Q = A5, nQ = 5A immediately. Clock edges while reset is low -> Q stays A5.
- Parallel load then hold: mode 11, D = 3C, en = 1, one edge -> Q = 3C. Then mode 00 for 3 edges -> Q = 3C. Then en = 0 with mode 11, D = FF -> Q stays 3C.
- Shift right: Q = 81, mode 01, sin_r = 0, 4 edges -> Q = 08. sout_r sequence before each edge: 1, 0, 0, 0.
- Shift left then rotate: Q = 81, mode 10, sin_l = 1, one edge -> Q = 03. Then rotate = 1, mode 01, one edge -> Q = 81.
- Clear priority: Q = FF, clr = 1, en = 0, mode 11, D = AA -> Q = 00 after one edge.
- Reset mid-shift and boundary: during a mode 01 sequence, pulse reset low for half a cycle -> Q = A5. With WIDTH = 1, RESET_VALUE = 1: rotate 1, shift 3 edges -> Q = 1; rotate 0, sin_l = 0, mode 10 -> Q = 0.
